bcd_scan_ctrl: RTL and testbench

BCD_SCAN_CTRL -- requirements
Module: bcd_scan_ctrl

---
 rtl/bcd_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: four-digit multiplexed seven-segment scanner for BCD values.
// Each digit is driven for DWELL clocks, followed by GAP blank clocks. A new value
// loaded during a scan is held as pending. It becomes visible only at the start of
// the next frame, so a frame never shows a mix of old and new digits.
module bcd_scan_ctrl #(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned GAP   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic        lzb,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done,
  output logic        upd_pend
);

  localparam int unsigned CMAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAPS  = 2'd2
  } state_t;

  state_t        st, st_n;
  logic [1:0]    dig, dig_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   disp, disp_n;
  logic [15:0]   pv, pv_n;
  logic          valid, valid_n;
  logic          pend, pend_n;
  logic          commit;

  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          fd_n;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // State register plus registered outputs; reset blanks the display at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= IDLE;
      dig        <= '0;
      cnt        <= '0;
      disp       <= '0;
      pv         <= '0;
      valid      <= 1'b0;
      pend       <= 1'b0;
      an         <= '1;
      seg        <= '0;
      frame_done <= 1'b0;
    end else begin
      st         <= st_n;
      dig        <= dig_n;
      cnt        <= cnt_n;
      disp       <= disp_n;
      pv         <= pv_n;
      valid      <= valid_n;
      pend       <= pend_n;
      an         <= an_n;
      seg        <= seg_n;
      frame_done <= fd_n;
    end
  end

  assign upd_pend = pend;

  // Next-state logic for scan sequencing and display/pending register updates.
  always_comb begin
    st_n    = st;
    dig_n   = dig;
    cnt_n   = cnt;
    disp_n  = disp;
    pv_n    = pv;
    valid_n = valid;
    pend_n  = pend;
    commit  = 1'b0;

    case (st)
      IDLE: begin
        if (load) begin
          disp_n  = bcd_in;
          valid_n = 1'b1;
          pend_n  = 1'b0;
        end
        if (en && (valid || load)) begin
          st_n   = DRIVE;
          dig_n  = '0;
          cnt_n  = '0;
          commit = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt == DWELL_LAST) begin
          st_n  = GAPS;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      GAPS: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (en) begin
            st_n   = DRIVE;
            dig_n  = dig + 2'd1;
            commit = (dig == 2'd3);
          end else begin
            st_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        st_n  = IDLE;
        dig_n = '0;
        cnt_n = '0;
      end
    endcase

    // Only the edge that starts a frame may change the display register.
    // A load on that same edge takes priority over the older pending value.
    if (commit) begin
      if (load) begin
        disp_n = bcd_in;
        pend_n = 1'b0;
      end else if (pend) begin
        disp_n = pv;
        pend_n = 1'b0;
      end
    end else if (st != IDLE && load) begin
      pv_n   = bcd_in;
      pend_n = 1'b1;
    end
  end

  // Output values are derived from next-state values so the registered outputs track the state.
  always_comb begin
    an_n  = '1;
    seg_n = '0;
    nib   = disp_n[{dig_n, 2'b00} +: 4];
    blank = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k >= 32'(dig_n) && disp_n[4*k +: 4] != 4'd0) blank = 1'b0;
    end
    blank = blank && lzb && (dig_n != 2'd0);
    if (st_n == DRIVE) begin
      an_n       = '1;
      an_n[dig_n] = 1'b0;
      seg_n      = blank ? 7'h00 : seg_decode(nib);
    end
    fd_n = (st_n == GAPS) && (dig_n == 2'd3) && (cnt_n == GAP_LAST);
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Testbench for bcd_scan_ctrl: randomized stimulus compared against a frame-position model.
module tb_bcd_scan_ctrl;

  localparam int unsigned DWELL = 4;
  localparam int unsigned GAP   = 2;
  localparam int SLOT  = DWELL + GAP;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;
  logic        upd_pend;

  always #5 clk = ~clk;

  bcd_scan_ctrl #(.DWELL(DWELL), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in), .lzb(lzb),
    .an(an), .seg(seg), .frame_done(frame_done), .upd_pend(upd_pend)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Model: "active" with a position in the frame replaces any explicit state machine.
  bit          m_active, m_valid, m_pend;
  int          m_phase;
  logic [15:0] m_disp, m_pv;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_fd;

  task automatic model_reset();
    m_active = 0; m_valid = 0; m_pend = 0; m_phase = 0;
    m_disp = '0; m_pv = '0;
    m_an = 4'hF; m_seg = '0; m_fd = 1'b0;
  endtask

  task automatic model_step();
    int d, sub;
    if (!m_active) begin
      if (load) begin m_disp = bcd_in; m_valid = 1; m_pend = 0; end
      if (en && m_valid) begin
        m_active = 1;
        m_phase  = 0;
        if (!load && m_pend) begin m_disp = m_pv; m_pend = 0; end
      end
    end else if (m_phase % SLOT == SLOT - 1 && !en) begin
      m_active = 0;
      if (load) begin m_pv = bcd_in; m_pend = 1; end
    end else begin
      m_phase = (m_phase + 1) % FRAME;
      if (m_phase == 0) begin
        if (load) begin m_disp = bcd_in; m_pend = 0; end
        else if (m_pend) begin m_disp = m_pv; m_pend = 0; end
      end else if (load) begin
        m_pv = bcd_in; m_pend = 1;
      end
    end
    m_an = 4'hF; m_seg = '0; m_fd = 1'b0;
    if (m_active) begin
      d   = m_phase / SLOT;
      sub = m_phase % SLOT;
      if (sub < DWELL) begin
        m_an = 4'hF & ~(4'h1 << d);
        if (lzb && d > 0 && (m_disp >> (4 * d)) == 16'h0) m_seg = '0;
        else m_seg = seg_tbl[(m_disp >> (4 * d)) & 16'hF];
      end
      m_fd = (m_phase == FRAME - 1);
    end
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".an"}, {12'h0, an}, {12'h0, m_an});
    check({ctx, ".seg"}, {9'h0, seg}, {9'h0, m_seg});
    check({ctx, ".frame_done"}, {15'h0, frame_done}, {15'h0, m_fd});
    check({ctx, ".upd_pend"}, {15'h0, upd_pend}, {15'h0, m_pend});
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    int r;
    for (int k = 0; k < 4; k++) begin
      r = int'($urandom_range(0, 19));
      if (r < 8) v[4*k +: 4] = 4'd0;
      else if (r < 18) v[4*k +: 4] = 4'(r - 8);
      else v[4*k +: 4] = 4'(10 + $urandom_range(0, 5));
    end
    return v;
  endfunction

  // Clocks one edge with the inputs currently driven and advances the model in step.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  initial begin
    int rst_hold;
    model_reset();
    rst = 1'b0; en = 1'b1;
    repeat (3) tick();
    check_outputs("reset");
    rst = 1'b1;
    repeat (10) begin tick(); check_outputs("idle_noload"); end

    // Load 0x1234: the first digit (digit 0 = 4) should be visible right after the load edge.
    load = 1'b1; bcd_in = 16'h1234;
    tick();
    load = 1'b0;
    check("first_an", {12'h0, an}, 16'h000E);
    check("first_seg", {9'h0, seg}, 16'h0066);
    check_outputs("frame1234");
    repeat (2 * FRAME) begin tick(); check_outputs("frame1234"); end

    rst_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b1;
      end
      load   = ($urandom_range(0, 14) == 0);
      bcd_in = rand_bcd();
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) lzb = ~lzb;
      if (rst && rst_hold == 0 && $urandom_range(0, 799) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        rst_hold = 3;
      end
      tick();
      check_outputs("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
